// File: rtl/sm_clk_gen.sv
// sm_clk_gen: glitch-free tunable clock generator. Divides clkIn by a power-of-two
// (2^(SHIFT+devide), saturating) or linear (devide+1) half period selected at runtime.
// Ratio and enable changes only take effect at clk period boundaries.
// Optional feature macro: SM_CLKGEN_STEP_EN enables the single-period step request.
module sm_clk_gen #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned DIV_WIDTH   = 4,
  parameter int unsigned SHIFT       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clkIn,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] devide,
  input  logic                 mode,
  input  logic                 enable,
  input  logic                 step,
  output logic                 clk,
  output logic                 clkRise,
  output logic                 running
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
`ifdef SM_CLKGEN_STEP_EN
  localparam logic [1:0] STEP = 2'd2;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] H_RESET =
      (SHIFT > CNT_WIDTH - 1) ? (CNT_ONE << (CNT_WIDTH - 1)) : (CNT_ONE << SHIFT);

  logic [SYNC_STAGES-1:0][DIV_WIDTH-1:0] dev_sync_q;
  logic [SYNC_STAGES-1:0]                mode_sync_q;
  logic [SYNC_STAGES-1:0]                en_sync_q;
  logic [DIV_WIDTH-1:0]                  dev_s;
  logic                                  mode_s;
  logic                                  en_s;
  logic                                  step_rise;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cntr_q, cntr_d;
  logic [CNT_WIDTH-1:0] h_cur_q, h_cur_d;
  logic [CNT_WIDTH-1:0] h_new;
  logic                 clk_q, clk_d;
  logic                 rise_q, rise_d;

  // Synchronise the asynchronous control inputs
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      dev_sync_q  <= '0;
      mode_sync_q <= '0;
      en_sync_q   <= '0;
    end else begin
      dev_sync_q  <= {dev_sync_q[SYNC_STAGES-2:0], devide};
      mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], mode};
      en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], enable};
    end
  end

  assign dev_s  = dev_sync_q[SYNC_STAGES-1];
  assign mode_s = mode_sync_q[SYNC_STAGES-1];
  assign en_s   = en_sync_q[SYNC_STAGES-1];

`ifdef SM_CLKGEN_STEP_EN
  logic [SYNC_STAGES-1:0] step_sync_q;
  logic                   step_prev_q;

  // Synchronise step and keep its previous synced value for edge detection
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      step_sync_q <= '0;
      step_prev_q <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step};
      step_prev_q <= step_sync_q[SYNC_STAGES-1];
    end
  end

  assign step_rise = step_sync_q[SYNC_STAGES-1] & ~step_prev_q;
`else
  logic unused_step;
  assign unused_step = step;
  assign step_rise   = 1'b0;
`endif

  // Half period requested by the synced devide/mode, saturated in power-of-two mode
  always_comb begin
    int unsigned exp_v;
    exp_v = SHIFT + 32'(dev_s);
    if (mode_s) begin
      h_new = CNT_WIDTH'(dev_s) + CNT_ONE;
    end else if (exp_v > CNT_WIDTH - 1) begin
      h_new = CNT_ONE << (CNT_WIDTH - 1);
    end else begin
      h_new = CNT_ONE << exp_v;
    end
  end

  // FSM and half-period counter; hCur only reloads on a clk 0->1 transition
  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    h_cur_d = h_cur_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cntr_d = '0;
        clk_d  = 1'b0;
        // enable wins over a simultaneous step edge
        if (en_s || step_rise) begin
`ifdef SM_CLKGEN_STEP_EN
          state_d = en_s ? RUN : STEP;
`else
          state_d = RUN;
`endif
          h_cur_d = h_new;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
        end
      end
`ifdef SM_CLKGEN_STEP_EN
      RUN, STEP: begin
`else
      RUN: begin
`endif
        if (cntr_q == h_cur_q - CNT_ONE) begin
          cntr_d = '0;
          clk_d  = ~clk_q;
          if (!clk_q) begin
            h_cur_d = h_new;
            rise_d  = 1'b1;
          end else begin
            // Falling edge ends a period: STEP and RUN both continue only if enabled
            state_d = en_s ? RUN : IDLE;
          end
        end else begin
          cntr_d = cntr_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cntr_d  = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset drops clk asynchronously
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cntr_q  <= '0;
      h_cur_q <= H_RESET;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      h_cur_q <= h_cur_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
    end
  end

  assign clk     = clk_q;
  assign clkRise = rise_q;
  assign running = (state_q != IDLE);

endmodule

// File: tb/tb_sm_clk_gen.sv
// Directed bench for sm_clk_gen with SHIFT=2, CNT_WIDTH=8, SYNC_STAGES=2.
// Expected clk periods are queued when stimulus is applied and compared as clk runs.
module tb_sm_clk_gen;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 4;
  localparam int HOLD = -1;   // low phase expected to persist (back to idle)
  localparam int HOLD_LEN = 40;

  logic          clkIn = 1'b0;
  logic          rst_n;
  logic [DW-1:0] devide;
  logic          mode;
  logic          enable;
  logic          step;
  logic          clk;
  logic          clkRise;
  logic          running;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    hi;
    int    lo;
  } exp_t;

  exp_t sb[$];

  sm_clk_gen #(
    .CNT_WIDTH  (CW),
    .DIV_WIDTH  (DW),
    .SHIFT      (2),
    .SYNC_STAGES(2)
  ) dut (
    .clkIn  (clkIn),
    .rst_n  (rst_n),
    .devide (devide),
    .mode   (mode),
    .enable (enable),
    .step   (step),
    .clk    (clk),
    .clkRise(clkRise),
    .running(running)
  );

  always #5 clkIn = ~clkIn;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clkIn cycle and sample just after the edge
  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  // Cycles until clk is seen high, bounded by limit
  task automatic wait_rise(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (clk !== 1'b1 && n < limit);
  endtask

  // Length of the current clk level (starting at a sample where clk == lvl)
  task automatic measure(input logic lvl, input int limit, output int len, inout int rises);
    len = 0;
    while (clk === lvl && len < limit) begin
      if (clkRise === 1'b1) rises++;
      len++;
      tick();
    end
  endtask

  // Pop the next expected period and measure it; must start at the first high sample
  task automatic check_period();
    exp_t e;
    int   hl;
    int   ll;
    int   rises;
    int   lo_exp;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    rises = 0;
    chk({e.tag, "_rise_strobe"}, int'(clkRise), 1);
    measure(1'b1, e.hi + 4, hl, rises);
    chk({e.tag, "_high"}, hl, e.hi);
    lo_exp = (e.lo == HOLD) ? HOLD_LEN : e.lo;
    measure(1'b0, lo_exp + 4 - ((e.lo == HOLD) ? 4 : 0), ll, rises);
    chk({e.tag, "_low"}, ll, lo_exp);
    chk({e.tag, "_rises"}, rises, 1);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    devide = '0;
    mode   = 1'b0;
    enable = 1'b0;
    step   = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_clk", int'(clk), 0);
    chk("rst_rise", int'(clkRise), 0);
    chk("rst_running", int'(running), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Power-of-two, devide=0: 4/4 periods, first rise 3 cycles after enable
    enable = 1'b1;
    wait_rise(20, n);
    chk("p2_latency", n, 3);
    chk("p2_running", int'(running), 1);
    repeat (3) sb.push_back('{"p2", 4, 4});
    repeat (3) check_period();

    // Drop enable at the start of a high phase: full period then idle
    enable = 1'b0;
    sb.push_back('{"p2_off", 4, HOLD});
    check_period();
    chk("p2_off_running", int'(running), 0);

    // Linear devide=2 (3/3), then devide=0 mid-high: that period 3/3, then 1/1
    mode   = 1'b1;
    devide = 4'd2;
    enable = 1'b1;
    wait_rise(20, n);
    chk("lin_latency", n, 3);
    sb.push_back('{"lin3a", 3, 3});
    sb.push_back('{"lin3b", 3, 3});
    sb.push_back('{"lin1a", 1, 1});
    sb.push_back('{"lin1b", 1, 1});
    check_period();
    devide = 4'd0;
    repeat (3) check_period();
    enable = 1'b0;
    n = 0;
    while (running === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("lin_stop_running", int'(running), 0);
    chk("lin_stop_clk", int'(clk), 0);

    // Power-of-two saturation: 2^(2+7) clipped to 128
    mode   = 1'b0;
    devide = 4'd7;
    enable = 1'b1;
    wait_rise(20, n);
    chk("sat_latency", n, 3);
    sb.push_back('{"sat", 128, 128});
    check_period();
    enable = 1'b0;
    sb.push_back('{"sat_off", 128, HOLD});
    check_period();
    chk("sat_off_running", int'(running), 0);

    // Single step with enable low
    devide = 4'd0;
    repeat (3) tick();
    step = 1'b1;
    tick();
    step = 1'b0;
`ifdef SM_CLKGEN_STEP_EN
    wait_rise(20, n);
    chk("step_latency", n, 2);
    sb.push_back('{"step", 4, HOLD});
    fork
      check_period();
      begin
        // Second step edge lands inside the period and must be dropped
        repeat (2) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
      end
    join
    chk("step_end_running", int'(running), 0);
`else
    wait_rise(20, n);
    chk("nostep_timeout", n, 20);
    chk("nostep_clk", int'(clk), 0);
    chk("nostep_running", int'(running), 0);
`endif

    // Reset during a high phase drops outputs without waiting for an edge
    enable = 1'b1;
    wait_rise(20, n);
    chk("prerst_latency", n, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_clk", int'(clk), 0);
    chk("midrst_rise", int'(clkRise), 0);
    chk("midrst_running", int'(running), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_rise(20, n);
    chk("postrst_latency", n, 3);
    sb.push_back('{"postrst", 4, 4});
    check_period();

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
